ahb_two_master_arbiter: RTL and testbench

//  AHB-Lite arbiter that lets two bus masters share one downstream AHB port to the uncore.
//  M0 is the pipelined core. M1 is a secondary master (debug module or DMA).

---
 rtl/ahb_two_master_arbiter.sv | 142 ++++++++++++++
 tb/tb_ahb_two_master_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_two_master_arbiter.sv
// Two-master AHB-Lite arbiter: park-on-owner, one IDLE bubble per handover.
// Define AHBARB_FAIRNESS_EN to enable starvation-driven forced handover.
module ahb_two_master_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   M0_HADDR,
  input  logic [DATA_W-1:0]   M0_HWDATA,
  input  logic [DATA_W/8-1:0] M0_HWSTRB,
  input  logic                M0_HWRITE,
  input  logic [2:0]          M0_HSIZE,
  input  logic [2:0]          M0_HBURST,
  input  logic [3:0]          M0_HPROT,
  input  logic [1:0]          M0_HTRANS,
  input  logic                M0_HMASTLOCK,
  output logic [DATA_W-1:0]   M0_HRDATA,
  output logic                M0_HREADY,
  output logic                M0_HRESP,
  input  logic [ADDR_W-1:0]   M1_HADDR,
  input  logic [DATA_W-1:0]   M1_HWDATA,
  input  logic [DATA_W/8-1:0] M1_HWSTRB,
  input  logic                M1_HWRITE,
  input  logic [2:0]          M1_HSIZE,
  input  logic [2:0]          M1_HBURST,
  input  logic [3:0]          M1_HPROT,
  input  logic [1:0]          M1_HTRANS,
  input  logic                M1_HMASTLOCK,
  output logic [DATA_W-1:0]   M1_HRDATA,
  output logic                M1_HREADY,
  output logic                M1_HRESP,
  output logic [ADDR_W-1:0]   S_HADDR,
  output logic [DATA_W-1:0]   S_HWDATA,
  output logic [DATA_W/8-1:0] S_HWSTRB,
  output logic                S_HWRITE,
  output logic [2:0]          S_HSIZE,
  output logic [2:0]          S_HBURST,
  output logic [3:0]          S_HPROT,
  output logic [1:0]          S_HTRANS,
  output logic                S_HMASTLOCK,
  input  logic [DATA_W-1:0]   S_HRDATA,
  input  logic                S_HREADY,
  input  logic                S_HRESP,
  output logic                GRANT
);

  // state | meaning
  // aown  | address-phase owner (0=M0, 1=M1)
  // down  | data-phase owner
  // dact  | a data phase is outstanding
  // wcnt  | cycles the non-owner has been requesting

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam int         CW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM    = CW'(STARVE_LIMIT);

  logic          aown, aown_nxt;
  logic          down, down_nxt;
  logic          dact, dact_nxt;
  logic [CW-1:0] wcnt, wcnt_nxt;
  logic [1:0]    own_trans;
  logic          own_lock, req0, req1, req_other, hold, force_sw, sw, blk;

  always_ff @(posedge clk) begin
    if (reset) begin
      aown <= 1'b0;
      down <= 1'b0;
      dact <= 1'b0;
      wcnt <= '0;
    end else begin
      aown <= aown_nxt;
      down <= down_nxt;
      dact <= dact_nxt;
      wcnt <= wcnt_nxt;
    end
  end

`ifdef AHBARB_FAIRNESS_EN
  always_comb force_sw = (wcnt == LIM);
`else
  always_comb force_sw = 1'b0;
`endif

  // A switch needs a ready bus, an unheld owner and a NONSEQ from the other master.
  always_comb begin
    own_trans = aown ? M1_HTRANS : M0_HTRANS;
    own_lock  = aown ? M1_HMASTLOCK : M0_HMASTLOCK;
    req0      = (M0_HTRANS == HT_NONSEQ);
    req1      = (M1_HTRANS == HT_NONSEQ);
    req_other = aown ? req0 : req1;
    hold      = own_lock | (own_trans == HT_SEQ) | (own_trans == HT_BUSY);
    sw        = ~reset & S_HREADY & ~hold & req_other
                & ((own_trans == HT_IDLE) | force_sw);
    blk       = sw & (own_trans == HT_NONSEQ);
  end

  always_comb begin
    aown_nxt = aown;
    down_nxt = down;
    dact_nxt = dact;
    wcnt_nxt = wcnt;
    if (sw) aown_nxt = ~aown;
    if (S_HREADY) begin
      dact_nxt = (S_HTRANS == HT_NONSEQ) | (S_HTRANS == HT_SEQ);
      down_nxt = aown;
    end
    if (sw)
      wcnt_nxt = '0;
    else if (req_other && (wcnt != LIM))
      wcnt_nxt = wcnt + 1'b1;
  end

  always_comb begin
    S_HADDR     = aown ? M1_HADDR  : M0_HADDR;
    S_HWRITE    = aown ? M1_HWRITE : M0_HWRITE;
    S_HSIZE     = aown ? M1_HSIZE  : M0_HSIZE;
    S_HBURST    = aown ? M1_HBURST : M0_HBURST;
    S_HPROT     = aown ? M1_HPROT  : M0_HPROT;
    S_HTRANS    = (reset | sw) ? HT_IDLE : own_trans;
    S_HMASTLOCK = ~reset & own_lock;
    S_HWDATA    = down ? M1_HWDATA : M0_HWDATA;
    S_HWSTRB    = down ? M1_HWSTRB : M0_HWSTRB;
    GRANT       = aown;
    M0_HRDATA   = S_HRDATA;
    M1_HRDATA   = S_HRDATA;
    M0_HRESP    = S_HRESP & dact & ~down;
    M1_HRESP    = S_HRESP & dact & down;
    // Data-phase owner sees the slave directly; the address owner is stalled only on a switch.
    if (dact && !down)  M0_HREADY = S_HREADY;
    else if (!aown)     M0_HREADY = S_HREADY & ~blk;
    else                M0_HREADY = 1'b0;
    if (dact && down)   M1_HREADY = S_HREADY;
    else if (aown)      M1_HREADY = S_HREADY & ~blk;
    else                M1_HREADY = 1'b0;
  end

endmodule

// File: tb/tb_ahb_two_master_arbiter.sv
// Self-checking bench for ahb_two_master_arbiter: directed scenarios plus a
// randomized run against a per-master behavioural model.
module tb_ahb_two_master_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int LIM = 4;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] haddr [2];
  logic [DW-1:0] hwdata [2];
  logic [SW-1:0] hwstrb [2];
  logic          hwrite [2];
  logic [2:0]    hsize [2];
  logic [2:0]    hburst [2];
  logic [3:0]    hprot [2];
  logic [1:0]    htrans [2];
  logic          hmastlock [2];
  logic [DW-1:0] m0_hrdata, m1_hrdata;
  logic          m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [AW-1:0] s_haddr;
  logic [DW-1:0] s_hwdata, s_hrdata;
  logic [SW-1:0] s_hwstrb;
  logic          s_hwrite, s_hmastlock, s_hready, s_hresp, grant;
  logic [2:0]    s_hsize, s_hburst;
  logic [3:0]    s_hprot;
  logic [1:0]    s_htrans;

  int errors = 0;
  int checks = 0;

  ahb_two_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .M0_HADDR(haddr[0]), .M0_HWDATA(hwdata[0]), .M0_HWSTRB(hwstrb[0]), .M0_HWRITE(hwrite[0]),
    .M0_HSIZE(hsize[0]), .M0_HBURST(hburst[0]), .M0_HPROT(hprot[0]), .M0_HTRANS(htrans[0]),
    .M0_HMASTLOCK(hmastlock[0]), .M0_HRDATA(m0_hrdata), .M0_HREADY(m0_hready), .M0_HRESP(m0_hresp),
    .M1_HADDR(haddr[1]), .M1_HWDATA(hwdata[1]), .M1_HWSTRB(hwstrb[1]), .M1_HWRITE(hwrite[1]),
    .M1_HSIZE(hsize[1]), .M1_HBURST(hburst[1]), .M1_HPROT(hprot[1]), .M1_HTRANS(htrans[1]),
    .M1_HMASTLOCK(hmastlock[1]), .M1_HRDATA(m1_hrdata), .M1_HREADY(m1_hready), .M1_HRESP(m1_hresp),
    .S_HADDR(s_haddr), .S_HWDATA(s_hwdata), .S_HWSTRB(s_hwstrb), .S_HWRITE(s_hwrite),
    .S_HSIZE(s_hsize), .S_HBURST(s_hburst), .S_HPROT(s_hprot), .S_HTRANS(s_htrans),
    .S_HMASTLOCK(s_hmastlock), .S_HRDATA(s_hrdata), .S_HREADY(s_hready), .S_HRESP(s_hresp),
    .GRANT(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int m = 0; m < 2; m++) begin
      htrans[m] = IDLE; hmastlock[m] = 1'b0; haddr[m] = '0; hwdata[m] = '0;
      hwstrb[m] = '0; hwrite[m] = 1'b0; hsize[m] = 3'd0; hburst[m] = 3'd0; hprot[m] = 4'd0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; idle_all(); s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_all(); s_hready = 1'b1; s_hresp = 1'b1; s_hrdata = '0;
    step(); step();
    settle();
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant); end
    checks++; if (s_htrans !== IDLE) begin errors++; $display("FAIL reset_htrans: got %b want 00", s_htrans); end
    checks++; if (s_hmastlock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b want 0", s_hmastlock); end
    checks++; if (m0_hready !== 1'b1) begin errors++; $display("FAIL reset_m0_ready: got %b want 1", m0_hready); end
    checks++; if (m1_hready !== 1'b0) begin errors++; $display("FAIL reset_m1_ready: got %b want 0", m1_hready); end
    checks++; if ({m0_hresp, m1_hresp} !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b want 00", {m0_hresp, m1_hresp}); end
    reset = 1'b0; s_hresp = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    logic [DW-1:0] rd;
    rd = 64'hDEAD_BEEF_0123_4567;
    do_reset();
    htrans[0] = NONSEQ; haddr[0] = 32'h8000_0000; hwrite[0] = 1'b0;
    settle();
    checks++; if (s_htrans !== NONSEQ) begin errors++; $display("FAIL read_htrans: got %b want 10", s_htrans); end
    checks++; if (s_haddr !== 32'h8000_0000) begin errors++; $display("FAIL read_haddr: got %h want 80000000", s_haddr); end
    checks++; if (m0_hready !== 1'b1) begin errors++; $display("FAIL read_addr_ready: got %b want 1", m0_hready); end
    step();
    htrans[0] = IDLE; s_hready = 1'b0; s_hrdata = rd;
    settle();
    checks++; if (m0_hready !== 1'b0) begin errors++; $display("FAIL read_wait_ready: got %b want 0", m0_hready); end
    step();
    s_hready = 1'b1;
    settle();
    checks++; if (m0_hready !== 1'b1) begin errors++; $display("FAIL read_data_ready: got %b want 1", m0_hready); end
    checks++; if (m0_hrdata !== rd) begin errors++; $display("FAIL read_hrdata: got %h want %h", m0_hrdata, rd); end
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL read_grant: got %b want 0", grant); end
    step();
  endtask

  task automatic test_handover();
    logic [DW-1:0] wd;
    do_reset();
    htrans[1] = NONSEQ; haddr[1] = 32'h0000_1000; hwrite[1] = 1'b1; hsize[1] = 3'd3;
    settle();
    checks++; if (s_htrans !== IDLE) begin errors++; $display("FAIL hand_bubble: got %b want 00", s_htrans); end
    checks++; if (m1_hready !== 1'b0) begin errors++; $display("FAIL hand_m1_stall: got %b want 0", m1_hready); end
    step();
    settle();
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL hand_grant: got %b want 1", grant); end
    checks++; if (s_htrans !== NONSEQ) begin errors++; $display("FAIL hand_htrans: got %b want 10", s_htrans); end
    checks++; if ({s_haddr, s_hwrite} !== {32'h0000_1000, 1'b1}) begin errors++; $display("FAIL hand_addr: got %h/%b want 00001000/1", s_haddr, s_hwrite); end
    step();
    wd = {$urandom, $urandom};
    htrans[1] = IDLE; hwdata[1] = wd; hwstrb[1] = 8'hFF; hwdata[0] = ~wd;
    settle();
    checks++; if (s_hwdata !== wd) begin errors++; $display("FAIL hand_hwdata: got %h want %h", s_hwdata, wd); end
    checks++; if (s_hwstrb !== 8'hFF) begin errors++; $display("FAIL hand_hwstrb: got %h want ff", s_hwstrb); end
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL hand_park: got %b want 1", grant); end
    step();
  endtask

  task automatic test_burst();
    logic [AW-1:0] base;
    logic [1:0]    et;
    base = 32'h4000_0100;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      et = (b == 0) ? NONSEQ : SEQ;
      htrans[0] = et; haddr[0] = base + AW'(b * 8); hburst[0] = 3'b011;
      htrans[1] = (b >= 1) ? NONSEQ : IDLE; haddr[1] = 32'h0000_2000;
      settle();
      checks++; if (s_htrans !== et) begin errors++; $display("FAIL burst_htrans beat %0d: got %b want %b", b, s_htrans, et); end
      checks++; if (s_haddr !== base + AW'(b * 8)) begin errors++; $display("FAIL burst_haddr beat %0d: got %h", b, s_haddr); end
      checks++; if ({grant, m0_hready, m1_hready} !== 3'b010) begin errors++; $display("FAIL burst_ctl beat %0d: got grant/r0/r1=%b want 010", b, {grant, m0_hready, m1_hready}); end
      step();
    end
    htrans[0] = IDLE;
    settle();
    checks++; if ({grant, s_htrans, m1_hready} !== {1'b0, IDLE, 1'b0}) begin errors++; $display("FAIL burst_switch: got grant/htrans/r1=%b want 0000", {grant, s_htrans, m1_hready}); end
    step();
    settle();
    checks++; if ({grant, s_htrans} !== {1'b1, NONSEQ}) begin errors++; $display("FAIL burst_m1: got grant/htrans=%b want 110", {grant, s_htrans}); end
    checks++; if (s_haddr !== 32'h0000_2000) begin errors++; $display("FAIL burst_m1_addr: got %h want 00002000", s_haddr); end
    step();
    idle_all();
  endtask

  task automatic test_error();
    do_reset();
    htrans[1] = NONSEQ; hwrite[1] = 1'b1; haddr[1] = 32'h0000_3000;
    step();
    settle();
    checks++; if ({grant, s_htrans} !== {1'b1, NONSEQ}) begin errors++; $display("FAIL err_addr: got grant/htrans=%b want 110", {grant, s_htrans}); end
    step();
    htrans[1] = IDLE; htrans[0] = NONSEQ; s_hready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      settle();
      checks++; if ({m1_hready, m1_hresp, m0_hready, grant} !== 4'b0001) begin errors++; $display("FAIL err_wait %0d: got r1/e1/r0/grant=%b want 0001", w, {m1_hready, m1_hresp, m0_hready, grant}); end
      step();
    end
    s_hresp = 1'b1;
    settle();
    checks++; if ({m1_hresp, m0_hresp, m1_hready, grant} !== 4'b1001) begin errors++; $display("FAIL err_cycle1: got e1/e0/r1/grant=%b want 1001", {m1_hresp, m0_hresp, m1_hready, grant}); end
    step();
    s_hready = 1'b1;
    settle();
    checks++; if ({m1_hresp, m0_hresp, m1_hready, grant} !== 4'b1011) begin errors++; $display("FAIL err_cycle2: got e1/e0/r1/grant=%b want 1011", {m1_hresp, m0_hresp, m1_hready, grant}); end
    step();
    s_hresp = 1'b0;
    settle();
    checks++; if ({m1_hresp, grant} !== 2'b00) begin errors++; $display("FAIL err_after: got e1/grant=%b want 00", {m1_hresp, grant}); end
    step();
    idle_all();
  endtask

  task automatic test_starve();
    int first;
    logic [2:0] at_lim;
    first = -1; at_lim = 3'b000;
    do_reset();
    htrans[0] = NONSEQ; htrans[1] = NONSEQ; haddr[1] = 32'h0000_5000;
    for (int c = 0; c < 100 && first < 0; c++) begin
      haddr[0] = $urandom;
      settle();
      if (grant === 1'b1) first = c;
      if (c == LIM) at_lim = {s_htrans, m0_hready};
      step();
    end
`ifdef AHBARB_FAIRNESS_EN
    checks++; if (first != LIM + 1) begin errors++; $display("FAIL starve_flip: got cycle %0d want %0d", first, LIM + 1); end
    checks++; if (at_lim !== {IDLE, 1'b0}) begin errors++; $display("FAIL starve_switch: got htrans/r0=%b want 000", at_lim); end
`else
    checks++; if (first != -1) begin errors++; $display("FAIL starve_park: grant seen at cycle %0d want none in 100", first); end
`endif
    idle_all();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    htrans[1] = NONSEQ; hwrite[1] = 1'b1; haddr[1] = 32'h0000_6000;
    step(); step();
    s_hready = 1'b0;
    reset = 1'b1;
    step();
    settle();
    checks++; if ({grant, s_htrans, m1_hready, m0_hready} !== 5'b00000) begin errors++; $display("FAIL rmid_state: got grant/htrans/r1/r0=%b want 00000", {grant, s_htrans, m1_hready, m0_hready}); end
    s_hready = 1'b1;
    #1;
    checks++; if ({m0_hready, m1_hready} !== 2'b10) begin errors++; $display("FAIL rmid_ready: got r0/r1=%b want 10", {m0_hready, m1_hready}); end
    reset = 1'b0;
    idle_all();
    step();
  endtask

  task automatic test_random();
    int own, dm, wc, oth;
    bit dv, hold, frc, swx;
    logic [1:0] et;
    logic [1:0] erdy, eresp;
    int r;
    do_reset();
    own = 0; dm = 0; wc = 0; dv = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < 2; m++) begin
        r = $urandom_range(0, 9);
        htrans[m] = (r < 3) ? IDLE : (r < 7) ? NONSEQ : (r < 9) ? SEQ : BUSY;
        hmastlock[m] = ($urandom_range(0, 9) == 0);
        haddr[m] = $urandom; hwdata[m] = {$urandom, $urandom}; hwstrb[m] = 8'($urandom);
        hwrite[m] = 1'($urandom); hsize[m] = 3'($urandom); hburst[m] = 3'($urandom); hprot[m] = 4'($urandom);
      end
      s_hready = ($urandom_range(0, 3) != 0);
      s_hresp  = ($urandom_range(0, 7) == 0);
      s_hrdata = {$urandom, $urandom};
      settle();
      oth  = 1 - own;
      hold = hmastlock[own] || htrans[own] == SEQ || htrans[own] == BUSY;
      frc  = 1'b0;
`ifdef AHBARB_FAIRNESS_EN
      frc  = (wc == LIM);
`endif
      swx  = s_hready && !hold && htrans[oth] == NONSEQ && (htrans[own] == IDLE || frc);
      et   = swx ? IDLE : htrans[own];
      for (int m = 0; m < 2; m++) begin
        if (dv && dm == m)  erdy[m] = s_hready;
        else if (own == m)  erdy[m] = s_hready && !(swx && htrans[m] == NONSEQ);
        else                erdy[m] = 1'b0;
        eresp[m] = s_hresp && dv && dm == m;
      end
      checks++; if (grant !== 1'(own)) begin errors++; $display("FAIL rnd_grant n=%0d: got %b want %0d", n, grant, own); end
      checks++; if (s_htrans !== et) begin errors++; $display("FAIL rnd_htrans n=%0d: got %b want %b", n, s_htrans, et); end
      checks++; if ({s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot, s_hmastlock} !== {haddr[own], hwrite[own], hsize[own], hburst[own], hprot[own], hmastlock[own]})
        begin errors++; $display("FAIL rnd_addrctl n=%0d: got %h want master %0d", n, {s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot, s_hmastlock}, own); end
      checks++; if ({s_hwdata, s_hwstrb} !== {hwdata[dm], hwstrb[dm]}) begin errors++; $display("FAIL rnd_wdata n=%0d: got %h want master %0d", n, s_hwdata, dm); end
      checks++; if ({m1_hready, m0_hready} !== erdy) begin errors++; $display("FAIL rnd_ready n=%0d: got r1r0=%b want %b", n, {m1_hready, m0_hready}, erdy); end
      checks++; if ({m1_hresp, m0_hresp} !== eresp) begin errors++; $display("FAIL rnd_resp n=%0d: got e1e0=%b want %b", n, {m1_hresp, m0_hresp}, eresp); end
      checks++; if ({m0_hrdata, m1_hrdata} !== {s_hrdata, s_hrdata}) begin errors++; $display("FAIL rnd_rdata n=%0d: got %h/%h want %h", n, m0_hrdata, m1_hrdata, s_hrdata); end
      if (s_hready) begin
        dv = (et == NONSEQ || et == SEQ);
        dm = own;
      end
      if (swx) wc = 0;
      else if (htrans[oth] == NONSEQ && wc < LIM) wc++;
      if (swx) own = oth;
      step();
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_handover();
    test_burst();
    test_error();
    test_starve();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
